// File: rtl/sprite_compositor.sv
// Multi-slot animated sprite compositor: descriptor bank, per-slot frame animation and a
// 3-stage pixel pipeline (ROM address, ROM read, priority select). Macro SPRITE_FLIP_EN enables horizontal mirroring.
module sprite_compositor #(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_W     = 18,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int COORD_W    = 10
) (
  input  logic                           pixel_Clk,
  input  logic                           Reset_n,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic                           frame_tick,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0]   cfg_slot,
  input  logic [2:0]                     cfg_field,
  input  logic [ADDR_W-1:0]              cfg_data,
  output logic [NUM_SLOTS*ADDR_W-1:0]    rom_addr,
  input  logic [NUM_SLOTS*IDX_W-1:0]     rom_data,
  output logic [IDX_W-1:0]               pix_index,
  output logic                           pix_hit,
  output logic [$clog2(NUM_SLOTS)-1:0]   pix_slot
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = COORD_W + 1;

  typedef enum logic [2:0] {
    F_X, F_Y, F_BASE, F_W, F_H, F_FSIZE, F_NFRAMES, F_CTRL
  } field_e;

  logic [COORD_W-1:0] x_q     [NUM_SLOTS];
  logic [COORD_W-1:0] y_q     [NUM_SLOTS];
  logic [7:0]         w_q     [NUM_SLOTS];
  logic [7:0]         h_q     [NUM_SLOTS];
  logic [ADDR_W-1:0]  base_q  [NUM_SLOTS];
  logic [ADDR_W-1:0]  fsize_q [NUM_SLOTS];
  logic [ADDR_W-1:0]  foff_q  [NUM_SLOTS];
  logic [3:0]         nfr_q   [NUM_SLOTS];
  logic [3:0]         fidx_q  [NUM_SLOTS];
  logic [6:0]         ctrl_q  [NUM_SLOTS];
  logic [4:0]         div_q   [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] wr_sel, restart, step;
  logic [4:0]           per_m1 [NUM_SLOTS];
  logic [3:0]           last_f [NUM_SLOTS];

  // A BASE/NFRAMES write restarts the animation and swallows a coincident tick.
  always_comb begin
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      wr_sel[s]  = cfg_we && (cfg_slot == SW'(s));
      restart[s] = wr_sel[s] && (cfg_field == F_BASE || cfg_field == F_NFRAMES);
      step[s]    = frame_tick && ctrl_q[s][0] && !restart[s];
      per_m1[s]  = (ctrl_q[s][5:1] == '0) ? '0 : ctrl_q[s][5:1] - 5'd1;
      last_f[s]  = (nfr_q[s] == '0) ? '0 : nfr_q[s] - 4'd1;
    end
  end

  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        x_q[s] <= '0;  y_q[s] <= '0;  w_q[s] <= '0;  h_q[s] <= '0;
        base_q[s] <= '0;  fsize_q[s] <= '0;  foff_q[s] <= '0;
        nfr_q[s] <= '0;  fidx_q[s] <= '0;  ctrl_q[s] <= '0;  div_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (wr_sel[s]) begin
          case (field_e'(cfg_field))
            F_X:       x_q[s]     <= cfg_data[COORD_W-1:0];
            F_Y:       y_q[s]     <= cfg_data[COORD_W-1:0];
            F_BASE:    base_q[s]  <= cfg_data;
            F_W:       w_q[s]     <= cfg_data[7:0];
            F_H:       h_q[s]     <= cfg_data[7:0];
            F_FSIZE:   fsize_q[s] <= cfg_data;
            F_NFRAMES: nfr_q[s]   <= cfg_data[3:0];
            F_CTRL:    ctrl_q[s]  <= cfg_data[6:0];
          endcase
        end
        if (restart[s]) begin
          fidx_q[s] <= '0;
          foff_q[s] <= '0;
          div_q[s]  <= '0;
        end else if (step[s]) begin
          if (div_q[s] == per_m1[s]) begin
            div_q[s] <= '0;
            if (fidx_q[s] == last_f[s]) begin
              fidx_q[s] <= '0;
              foff_q[s] <= '0;
            end else begin
              fidx_q[s] <= fidx_q[s] + 4'd1;
              foff_q[s] <= foff_q[s] + fsize_q[s];
            end
          end else begin
            div_q[s] <= div_q[s] + 5'd1;
          end
        end
      end
    end
  end

  logic [NUM_SLOTS-1:0] hit_c, hit1, hit2;
  logic [CW-1:0]        x_end  [NUM_SLOTS];
  logic [CW-1:0]        y_end  [NUM_SLOTS];
  logic [COORD_W-1:0]   col_c  [NUM_SLOTS];
  logic [COORD_W-1:0]   row_c  [NUM_SLOTS];
  logic [ADDR_W-1:0]    addr_c [NUM_SLOTS];
`ifndef SPRITE_FLIP_EN
  logic [NUM_SLOTS-1:0] unused_flip;
`endif

  // Bounds use one extra bit so sprites may run past the right/bottom edge without wrapping.
  always_comb begin
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      x_end[s] = CW'(x_q[s]) + CW'(w_q[s]);
      y_end[s] = CW'(y_q[s]) + CW'(h_q[s]);
      hit_c[s] = ctrl_q[s][0] && (DrawX >= x_q[s]) && (CW'(DrawX) < x_end[s])
                 && (DrawY >= y_q[s]) && (CW'(DrawY) < y_end[s]);
      row_c[s] = DrawY - y_q[s];
`ifdef SPRITE_FLIP_EN
      col_c[s] = ctrl_q[s][6] ? COORD_W'(x_end[s] - CW'(1) - CW'(DrawX)) : DrawX - x_q[s];
`else
      col_c[s] = DrawX - x_q[s];
      unused_flip[s] = ctrl_q[s][6];
`endif
      addr_c[s] = base_q[s] + foff_q[s] + ADDR_W'(row_c[s]) * ADDR_W'(w_q[s])
                  + ADDR_W'(col_c[s]);
    end
  end

  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic [SW-1:0]    win_slot;

  // Lowest-numbered opaque hit wins; transparent pixels fall through.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = IDX_W'(TRANSP_IDX);
    win_slot = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!win_any && hit2[s] && rom_data[s*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX)) begin
        win_any  = 1'b1;
        win_idx  = rom_data[s*IDX_W +: IDX_W];
        win_slot = SW'(s);
      end
    end
  end

  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      hit1      <= '0;
      hit2      <= '0;
      pix_hit   <= 1'b0;
      pix_index <= '0;
      pix_slot  <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++)
        rom_addr[s*ADDR_W +: ADDR_W] <= hit_c[s] ? addr_c[s] : '0;
      hit1      <= hit_c;
      hit2      <= hit1;
      pix_hit   <= win_any;
      pix_index <= win_idx;
      pix_slot  <= win_slot;
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus randomized streaming against a
// descriptor-level reference model; a synchronous ROM model supplies rom_data.
`timescale 1ns/1ps
module tb_sprite_compositor;
  localparam int NS = 4, AW = 18, IW = 4;
  localparam int AMOD = 1 << AW;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic frame_tick = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_slot = '0;
  logic [2:0] cfg_field = '0;
  logic [AW-1:0] cfg_data = '0;
  logic [NS*AW-1:0] rom_addr;
  logic [NS*IW-1:0] rom_data = '0;
  logic [IW-1:0] pix_index;
  logic pix_hit;
  logic [1:0] pix_slot;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sprite_compositor #(.NUM_SLOTS(NS), .ADDR_W(AW), .IDX_W(IW), .TRANSP_IDX(0), .COORD_W(10)) dut (
    .pixel_Clk(clk), .Reset_n(rst_n), .DrawX(DrawX), .DrawY(DrawY), .frame_tick(frame_tick),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_index(pix_index), .pix_hit(pix_hit),
    .pix_slot(pix_slot));

  // ROM contents: hashed per slot, or a forced constant when force_val >= 0
  int force_val[NS] = '{-1, -1, -1, -1};
  function automatic int rom_fn(int s, int a);
    if (force_val[s] >= 0) return force_val[s];
    return ((a * 7) ^ (a >> 5) ^ (s * 5)) & 15;
  endfunction

  always @(posedge clk)
    for (int s = 0; s < NS; s++)
      rom_data[s*IW +: IW] <= IW'(rom_fn(s, int'(rom_addr[s*AW +: AW])));

  // Reference model: descriptors plus a count of accepted animation ticks per slot
  int m_x[NS], m_y[NS], m_w[NS], m_h[NS], m_base[NS], m_fsize[NS], m_nf[NS], m_ctrl[NS], m_ticks[NS];

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_w[s] = 0; m_h[s] = 0; m_base[s] = 0;
      m_fsize[s] = 0; m_nf[s] = 0; m_ctrl[s] = 0; m_ticks[s] = 0;
    end
  endfunction

  function automatic void model_write(int s, int f, int d);
    case (f)
      0: m_x[s] = d & 1023;
      1: m_y[s] = d & 1023;
      2: begin m_base[s] = d; m_ticks[s] = 0; end
      3: m_w[s] = d & 255;
      4: m_h[s] = d & 255;
      5: m_fsize[s] = d;
      6: begin m_nf[s] = d & 15; m_ticks[s] = 0; end
      default: m_ctrl[s] = d & 127;
    endcase
  endfunction

  function automatic int m_foff(int s);
    int nf = (m_nf[s] == 0) ? 1 : m_nf[s];
    int p = (m_ctrl[s] >> 1) & 31;
    if (p == 0) p = 1;
    return int'((longint'(m_fsize[s]) * ((m_ticks[s] / p) % nf)) % AMOD);
  endfunction

  function automatic bit m_hit(int s, int x, int y);
    return ((m_ctrl[s] & 1) != 0) && x >= m_x[s] && x < m_x[s] + m_w[s]
           && y >= m_y[s] && y < m_y[s] + m_h[s];
  endfunction

  function automatic int m_addr(int s, int x, int y);
    int col = x - m_x[s];
    if (!m_hit(s, x, y)) return 0;
    if (FLIP && ((m_ctrl[s] >> 6) & 1) != 0) col = m_x[s] + m_w[s] - 1 - x;
    return (m_base[s] + m_foff(s) + (y - m_y[s]) * m_w[s] + col) % AMOD;
  endfunction

  function automatic void m_pixel(int x, int y, output bit hit, output int idx, output int slot);
    hit = 0; idx = 0; slot = 0;
    for (int s = 0; s < NS; s++)
      if (!hit && m_hit(s, x, y)) begin
        int d = rom_fn(s, m_addr(s, x, y));
        if (d != 0) begin hit = 1; idx = d; slot = s; end
      end
  endfunction

  task automatic cfg_write(int s, int f, int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_slot = 2'(s); cfg_field = 3'(f); cfg_data = AW'(d);
    @(posedge clk); #1 cfg_we = 1'b0;
    model_write(s, f, d);
  endtask

  task automatic program_slot(int s, int x, int y, int w, int h, int base, int fsize, int nf, int ctrl);
    cfg_write(s, 0, x); cfg_write(s, 1, y); cfg_write(s, 2, base); cfg_write(s, 3, w);
    cfg_write(s, 4, h); cfg_write(s, 5, fsize); cfg_write(s, 6, nf); cfg_write(s, 7, ctrl);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int s = 0; s < NS; s++) if ((m_ctrl[s] & 1) != 0) m_ticks[s]++;
  endtask

  task automatic drive(int x, int y);
    @(negedge clk); DrawX = 10'(x); DrawY = 10'(y);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", rom_addr); end
    checks++; if (pix_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", pix_hit); end
    checks++; if (pix_index !== '0) begin errors++; $display("FAIL reset_index: got %0d expected 0", pix_index); end
    checks++; if (pix_slot !== '0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", pix_slot); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_addr();
    bit eh; int ei, es;
    program_slot(0, 100, 50, 88, 94, 207867, 0, 1, 1);
    drive(100, 50); @(negedge clk);
    checks++; if (rom_addr[0 +: AW] !== 18'd207867) begin errors++; $display("FAIL addr_origin: got %0d expected 207867", rom_addr[0 +: AW]); end
    drive(187, 143); @(negedge clk);
    checks++; if (rom_addr[0 +: AW] !== 18'd216138) begin errors++; $display("FAIL addr_corner: got %0d expected 216138", rom_addr[0 +: AW]); end
    m_pixel(187, 143, eh, ei, es);
    repeat (2) @(negedge clk);
    checks++; if ({pix_hit, pix_index} !== {eh, 4'(ei)}) begin errors++; $display("FAIL corner_pix: got hit=%b idx=%0d expected hit=%b idx=%0d", pix_hit, pix_index, eh, ei); end
    drive(188, 143); @(negedge clk);
    checks++; if (rom_addr[0 +: AW] !== '0) begin errors++; $display("FAIL addr_miss: got %0d expected 0", rom_addr[0 +: AW]); end
    repeat (2) @(negedge clk);
    checks++; if (pix_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", pix_hit); end
  endtask

  task automatic test_priority();
    int fv0[3] = '{0, 3, 0};
    int fv1[3] = '{5, 5, 0};
    bit eh[3] = '{1, 1, 0};
    int ei[3] = '{5, 3, 0};
    int es[3] = '{1, 0, 0};
    program_slot(1, 100, 50, 20, 20, 1000, 0, 1, 1);
    drive(105, 55);
    for (int i = 0; i < 3; i++) begin
      force_val[0] = fv0[i]; force_val[1] = fv1[i];
      repeat (4) @(negedge clk);
      checks++;
      if ({pix_hit, pix_index, pix_slot} !== {eh[i], 4'(ei[i]), 2'(es[i])}) begin
        errors++;
        $display("FAIL priority%0d: got hit=%b idx=%0d slot=%0d expected hit=%b idx=%0d slot=%0d",
                 i, pix_hit, pix_index, pix_slot, eh[i], ei[i], es[i]);
      end
    end
    force_val[0] = -1; force_val[1] = -1;
  endtask

  task automatic test_animation();
    int exp;
    program_slot(2, 300, 300, 10, 10, 1000, 8272, 2, 1 | (5 << 1));
    drive(300, 300);
    for (int t = 1; t <= 15; t++) begin
      tick(); @(posedge clk); @(negedge clk);
      exp = 1000 + (((t >= 5 && t < 10) || t == 15) ? 8272 : 0);
      if (t <= 10 || t == 15) begin
        checks++;
        if (rom_addr[2*AW +: AW] !== AW'(exp)) begin errors++; $display("FAIL anim_tick%0d: got %0d expected %0d", t, rom_addr[2*AW +: AW], exp); end
      end
    end
    @(negedge clk);
    frame_tick = 1'b1; cfg_we = 1'b1; cfg_slot = 2'd2; cfg_field = 3'd6; cfg_data = AW'(2);
    @(posedge clk); #1 frame_tick = 1'b0; cfg_we = 1'b0;
    for (int s = 0; s < NS; s++) if (s != 2 && (m_ctrl[s] & 1) != 0) m_ticks[s]++;
    model_write(2, 6, 2);
    @(posedge clk); @(negedge clk);
    checks++; if (rom_addr[2*AW +: AW] !== 18'd1000) begin errors++; $display("FAIL anim_write_wins: got %0d expected 1000", rom_addr[2*AW +: AW]); end
    for (int t = 1; t <= 5; t++) begin
      tick(); @(posedge clk); @(negedge clk);
      exp = (t == 5) ? 9272 : 1000;
      checks++;
      if (rom_addr[2*AW +: AW] !== AW'(exp)) begin errors++; $display("FAIL anim_restart%0d: got %0d expected %0d", t, rom_addr[2*AW +: AW], exp); end
    end
    cfg_write(2, 7, 5 << 1);
    repeat (6) tick();
    cfg_write(2, 7, 1 | (5 << 1));
    @(posedge clk); @(negedge clk);
    checks++; if (rom_addr[2*AW +: AW] !== 18'd9272) begin errors++; $display("FAIL anim_disabled_hold: got %0d expected 9272", rom_addr[2*AW +: AW]); end
  endtask

  task automatic test_edge();
    int ex[4] = '{639, 599, 639, 639};
    int ey[4] = '{405, 405, 420, 419};
    int ea[4] = '{5479, 0, 0, 6711};
    program_slot(3, 600, 400, 88, 20, 5000, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(ex[i], ey[i]); @(negedge clk);
      checks++;
      if (rom_addr[3*AW +: AW] !== AW'(ea[i])) begin errors++; $display("FAIL edge%0d: got %0d expected %0d", i, rom_addr[3*AW +: AW], ea[i]); end
    end
  endtask

  task automatic test_flip();
    int fx[2] = '{100, 187};
    int ea;
    program_slot(3, 100, 200, 88, 10, 0, 0, 1, 1 | 64);
    for (int i = 0; i < 2; i++) begin
      drive(fx[i], 200); @(negedge clk);
      ea = FLIP ? 187 - fx[i] : fx[i] - 100;
      checks++;
      if (rom_addr[3*AW +: AW] !== AW'(ea)) begin errors++; $display("FAIL flip%0d: got %0d expected %0d", i, rom_addr[3*AW +: AW], ea); end
    end
  endtask

  typedef struct { int stamp; logic [NS*AW-1:0] addr; bit hit; int idx; int slot; } exp_t;

  task automatic test_random();
    exp_t qa[$], qp[$];
    exp_t e;
    int x, y, s, n;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NS; k++)
        program_slot(k, (r == 2) ? $urandom_range(900, 1023) : $urandom_range(0, 300),
                     $urandom_range(0, 300), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), $urandom_range(0, 15),
                     $urandom_range(0, 127) | (($urandom_range(0, 3) != 0) ? 1 : 0));
      n = $urandom_range(0, 40);
      for (int t = 0; t < n; t++) tick();
      qa.delete(); qp.delete();
      for (int i = 0; i < 203; i++) begin
        @(negedge clk);
        if (qa.size() > 0 && qa[0].stamp == i - 1) begin
          e = qa.pop_front();
          checks++;
          if (rom_addr !== e.addr) begin errors++; $display("FAIL rand_addr r%0d i%0d: got %0h expected %0h", r, i, rom_addr, e.addr); end
        end
        if (qp.size() > 0 && qp[0].stamp == i - 3) begin
          e = qp.pop_front();
          checks++;
          if ({pix_hit, pix_index, pix_slot} !== {e.hit, 4'(e.idx), 2'(e.slot)}) begin
            errors++;
            $display("FAIL rand_pix r%0d i%0d: got hit=%b idx=%0d slot=%0d expected hit=%b idx=%0d slot=%0d",
                     r, i, pix_hit, pix_index, pix_slot, e.hit, e.idx, e.slot);
          end
        end
        if (i < 200) begin
          if ($urandom_range(0, 4) == 0) begin
            x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
          end else begin
            s = $urandom_range(0, NS - 1);
            x = m_x[s] + $urandom_range(0, m_w[s] + 1) - 1;
            y = m_y[s] + $urandom_range(0, m_h[s] + 1) - 1;
            x = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
            y = (y < 0) ? 0 : (y > 1023) ? 1023 : y;
          end
          DrawX = 10'(x); DrawY = 10'(y);
          e.stamp = i;
          for (int k = 0; k < NS; k++) e.addr[k*AW +: AW] = AW'(m_addr(k, x, y));
          m_pixel(x, y, e.hit, e.idx, e.slot);
          qa.push_back(e); qp.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    program_slot(0, 10, 10, 4, 4, 77, 0, 1, 1);
    force_val[0] = 9;
    drive(10, 10);
    repeat (4) @(negedge clk);
    checks++; if ({pix_hit, pix_index, pix_slot} !== {1'b1, 4'd9, 2'd0}) begin errors++; $display("FAIL pre_reset: got hit=%b idx=%0d slot=%0d expected hit=1 idx=9 slot=0", pix_hit, pix_index, pix_slot); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL midreset_addr: got %0h expected 0", rom_addr); end
    checks++; if ({pix_hit, pix_index, pix_slot} !== 7'd0) begin errors++; $display("FAIL midreset_pix: got hit=%b idx=%0d slot=%0d expected all 0", pix_hit, pix_index, pix_slot); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if ({pix_hit, rom_addr} !== '0) begin errors++; $display("FAIL post_reset_cleared: got hit=%b addr=%0h expected 0", pix_hit, rom_addr); end
    program_slot(0, 10, 10, 4, 4, 77, 0, 1, 1);
    repeat (4) @(negedge clk);
    checks++; if ({pix_hit, pix_index, pix_slot} !== {1'b1, 4'd9, 2'd0}) begin errors++; $display("FAIL post_reset_pix: got hit=%b idx=%0d slot=%0d expected hit=1 idx=9 slot=0", pix_hit, pix_index, pix_slot); end
    force_val[0] = -1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addr();
    test_priority();
    test_animation();
    test_edge();
    test_flip();
    test_random();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
